// File: rtl/wb_cntr_pkg.sv
// Shared definitions for the Wishbone counter-control slave:
// register offsets, CTRL bit positions and the byte-lane helper.
package wb_cntr_pkg;

    localparam int BITS_DEF = 20;

    // Register index = adr[4:2]
    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_LOAD   = 3'd1;
    localparam logic [2:0] REG_COUNT  = 3'd2;
    localparam logic [2:0] REG_CMP    = 3'd3;
    localparam logic [2:0] REG_STATUS = 3'd4;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_IRQ_EN = 1;

    function automatic logic [31:0] lane_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

endpackage

// File: rtl/wb_slave_if.sv
// Wishbone slave front end: window decode, single-cycle registered ack,
// and the write/read strobes plus register index for the register bank.
module wb_slave_if #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stb_i,
    input  logic        cyc_i,
    input  logic        we_i,
    input  logic [31:0] adr_i,
    output logic        ack_o,
    output logic        wr_stb_o,
    output logic        rd_stb_o,
    output logic [2:0]  reg_idx_o
);

    logic req;
    logic ack_q;
    logic unused_adr;

    assign unused_adr = &{1'b0, adr_i[1:0]};

    // Masking with ack_q turns a held strobe into one ack every other cycle.
    assign req = cyc_i & stb_i & (adr_i[31:5] == BASE_ADDR[31:5]) & ~ack_q;

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ack_q <= 1'b0;
        end else begin
            ack_q <= req;
        end
    end

    assign ack_o     = ack_q;
    assign wr_stb_o  = req & we_i;
    assign rd_stb_o  = req & ~we_i;
    assign reg_idx_o = adr_i[4:2];

endmodule

// File: rtl/wb_cntr_ctrl.sv
// Register bank giving the management SoC control of the user-area counter:
// enable, load, compare threshold, sticky match status and level interrupt.
module wb_cntr_ctrl
    import wb_cntr_pkg::*;
#(
    parameter int          BITS      = BITS_DEF,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            wbs_stb_i,
    input  logic            wbs_cyc_i,
    input  logic            wbs_we_i,
    input  logic [3:0]      wbs_sel_i,
    input  logic [31:0]     wbs_adr_i,
    input  logic [31:0]     wbs_dat_i,
    output logic            wbs_ack_o,
    output logic [31:0]     wbs_dat_o,
    input  logic [BITS-1:0] cnt_val_i,
    output logic            cnt_en_o,
    output logic            cnt_load_o,
    output logic [BITS-1:0] cnt_load_val_o,
    output logic            irq_o
);

    logic        wr_stb;
    logic        rd_stb;
    logic [2:0]  reg_idx;
    logic [31:0] wmask;
    logic        unused_bits;

    logic            en_q, en_d;
    logic            irq_en_q, irq_en_d;
    logic [BITS-1:0] load_q, load_d;
    logic [BITS-1:0] cmp_q, cmp_d;
    logic [BITS-1:0] count_q;
    logic            match_q, match_d;
    logic            match_clr;
    logic            load_pulse_q, load_pulse_d;
    logic [31:0]     dat_q, dat_d;
    logic [31:0]     rd_data;
    logic            irq_q, irq_d;

    wb_slave_if #(.BASE_ADDR(BASE_ADDR)) u_slave_if (
        .clk_i     (wb_clk_i),
        .rst_i     (wb_rst_i),
        .stb_i     (wbs_stb_i),
        .cyc_i     (wbs_cyc_i),
        .we_i      (wbs_we_i),
        .adr_i     (wbs_adr_i),
        .ack_o     (wbs_ack_o),
        .wr_stb_o  (wr_stb),
        .rd_stb_o  (rd_stb),
        .reg_idx_o (reg_idx)
    );

    assign wmask       = lane_mask(wbs_sel_i);
    assign unused_bits = &{1'b0, wmask, wbs_dat_i};

    // NOTE: every _d gets its hold value first so no latch is inferred.
    always_comb begin
        en_d         = en_q;
        irq_en_d     = irq_en_q;
        load_d       = load_q;
        cmp_d        = cmp_q;
        load_pulse_d = 1'b0;
        match_clr    = 1'b0;
        rd_data      = '0;

        if (wr_stb) begin
            case (reg_idx)
                REG_CTRL: begin
                    if (wbs_sel_i[0]) begin
                        en_d     = wbs_dat_i[CTRL_EN];
                        irq_en_d = wbs_dat_i[CTRL_IRQ_EN];
                    end
                end
                REG_LOAD: begin
                    load_d       = (load_q & ~wmask[BITS-1:0]) | (wbs_dat_i[BITS-1:0] & wmask[BITS-1:0]);
                    load_pulse_d = |wbs_sel_i;
                end
                REG_CMP:    cmp_d     = (cmp_q & ~wmask[BITS-1:0]) | (wbs_dat_i[BITS-1:0] & wmask[BITS-1:0]);
                REG_STATUS: match_clr = wbs_sel_i[0] & wbs_dat_i[0];
                default: ;
            endcase
        end

        case (reg_idx)
            REG_CTRL:   rd_data[1:0]      = {irq_en_q, en_q};
            REG_LOAD:   rd_data[BITS-1:0] = load_q;
            REG_COUNT:  rd_data[BITS-1:0] = count_q;
            REG_CMP:    rd_data[BITS-1:0] = cmp_q;
            REG_STATUS: rd_data[0]        = match_q;
            default: ;
        endcase

        // A new match outranks a simultaneous W1C so no event is lost.
        if (en_q && (cnt_val_i == cmp_q)) begin
            match_d = 1'b1;
        end else if (match_clr) begin
            match_d = 1'b0;
        end else begin
            match_d = match_q;
        end

        dat_d = rd_stb ? rd_data : 32'h0;
        irq_d = match_q & irq_en_q;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            en_q         <= 1'b0;
            irq_en_q     <= 1'b0;
            load_q       <= '0;
            cmp_q        <= '0;
            count_q      <= '0;
            match_q      <= 1'b0;
            load_pulse_q <= 1'b0;
            dat_q        <= 32'h0;
            irq_q        <= 1'b0;
        end else begin
            en_q         <= en_d;
            irq_en_q     <= irq_en_d;
            load_q       <= load_d;
            cmp_q        <= cmp_d;
            count_q      <= cnt_val_i;
            match_q      <= match_d;
            load_pulse_q <= load_pulse_d;
            dat_q        <= dat_d;
            irq_q        <= irq_d;
        end
    end

    assign wbs_dat_o      = dat_q;
    assign cnt_en_o       = en_q;
    assign cnt_load_o     = load_pulse_q;
    assign cnt_load_val_o = load_q;
    assign irq_o          = irq_q;

endmodule

// File: tb/tb_wb_cntr_ctrl.sv
// Self-checking bench for wb_cntr_ctrl: a vector table for register access
// plus directed sequences for match, interrupt, wrap, window and reset cases.
module tb_wb_cntr_ctrl;

    localparam int          BITS = 20;
    localparam logic [31:0] BASE = 32'h3000_0000;

    logic            clk = 1'b0;
    logic            rst;
    logic            stb, cyc, we;
    logic [3:0]      sel;
    logic [31:0]     adr, wdat;
    logic            ack;
    logic [31:0]     rdat;
    logic [BITS-1:0] cnt_val;
    logic            cnt_en, cnt_load;
    logic [BITS-1:0] cnt_load_val;
    logic            irq;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic            acked;
        int              lat;
        logic [31:0]     dat;
        logic            ld;
        logic [BITS-1:0] ldv;
        logic            irq;
    } snap_t;

    typedef struct {
        logic [BITS-1:0] cnt;
        logic            we;
        logic [4:0]      off;
        logic [3:0]      sel;
        logic [31:0]     wdat;
        logic [31:0]     exp_rd;
        logic            exp_ld;
    } vec_t;

    vec_t  vecs[25];
    snap_t s;

    wb_cntr_ctrl #(.BITS(BITS), .BASE_ADDR(BASE)) dut (
        .wb_clk_i       (clk),
        .wb_rst_i       (rst),
        .wbs_stb_i      (stb),
        .wbs_cyc_i      (cyc),
        .wbs_we_i       (we),
        .wbs_sel_i      (sel),
        .wbs_adr_i      (adr),
        .wbs_dat_i      (wdat),
        .wbs_ack_o      (ack),
        .wbs_dat_o      (rdat),
        .cnt_val_i      (cnt_val),
        .cnt_en_o       (cnt_en),
        .cnt_load_o     (cnt_load),
        .cnt_load_val_o (cnt_load_val),
        .irq_o          (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called 1 ns after a rising edge; returns 1 ns after the cycle following ack.
    task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [3:0] sl,
                           input logic [31:0] d, output snap_t r);
        r = '{1'b0, 0, 32'h0, 1'b0, '0, 1'b0};
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = sl; wdat = d;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (ack) begin
                r.acked = 1'b1;
                r.lat   = i;
                r.dat   = rdat;
                r.ld    = cnt_load;
                r.ldv   = cnt_load_val;
                r.irq   = irq;
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; wdat = 32'h0;
        tick();
    endtask

    task automatic wr(input logic [4:0] off, input logic [3:0] sl, input logic [31:0] d, output snap_t r);
        wb_xfer(1'b1, BASE + {27'h0, off}, sl, d, r);
    endtask

    task automatic rd(input logic [4:0] off, output snap_t r);
        wb_xfer(1'b0, BASE + {27'h0, off}, 4'h0, 32'h0, r);
    endtask

    logic [BITS-1:0] seq_cnt[5];
    logic            seq_irq[5];

    initial begin
        for (int i = 0; i < 8; i++)
            vecs[i] = '{20'h0, 1'b0, 5'(i * 4), 4'h0, 32'h0, 32'h0, 1'b0};
        vecs[8]  = '{20'h0,     1'b1, 5'h04, 4'hF, 32'h0001_2345, 32'h0,         1'b1};
        vecs[9]  = '{20'h0,     1'b0, 5'h04, 4'h0, 32'h0,         32'h0001_2345, 1'b0};
        vecs[10] = '{20'h55555, 1'b1, 5'h08, 4'hF, 32'h000F_FFFF, 32'h0,         1'b0};
        vecs[11] = '{20'h55555, 1'b0, 5'h08, 4'h0, 32'h0,         32'h0005_5555, 1'b0};
        vecs[12] = '{20'h55555, 1'b1, 5'h0C, 4'hF, 32'h000A_BCDE, 32'h0,         1'b0};
        vecs[13] = '{20'h55555, 1'b0, 5'h0C, 4'h0, 32'h0,         32'h000A_BCDE, 1'b0};
        vecs[14] = '{20'h55555, 1'b1, 5'h0C, 4'h4, 32'h0000_0000, 32'h0,         1'b0};
        vecs[15] = '{20'h55555, 1'b0, 5'h0C, 4'h0, 32'h0,         32'h0000_BCDE, 1'b0};
        vecs[16] = '{20'h55555, 1'b1, 5'h14, 4'hF, 32'hFFFF_FFFF, 32'h0,         1'b0};
        vecs[17] = '{20'h55555, 1'b0, 5'h14, 4'h0, 32'h0,         32'h0,         1'b0};
        vecs[18] = '{20'h55555, 1'b1, 5'h00, 4'h2, 32'hFFFF_FFFF, 32'h0,         1'b0};
        vecs[19] = '{20'h55555, 1'b0, 5'h00, 4'h0, 32'h0,         32'h0,         1'b0};
        vecs[20] = '{20'h55555, 1'b1, 5'h04, 4'h0, 32'h000F_FFFF, 32'h0,         1'b0};
        vecs[21] = '{20'h55555, 1'b0, 5'h04, 4'h0, 32'h0,         32'h0001_2345, 1'b0};
        vecs[22] = '{20'h55555, 1'b1, 5'h00, 4'hF, 32'hFFFF_FFFE, 32'h0,         1'b0};
        vecs[23] = '{20'h55555, 1'b0, 5'h00, 4'h0, 32'h0,         32'h0000_0002, 1'b0};
        vecs[24] = '{20'h55555, 1'b0, 5'h10, 4'h0, 32'h0,         32'h0,         1'b0};

        seq_cnt = '{20'h0000E, 20'h0000F, 20'h00010, 20'h00011, 20'h00012};
        seq_irq = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
        adr = 32'h0; wdat = 32'h0; cnt_val = '0;
        repeat (3) tick();
        check("reset ack",      {31'h0, ack},        32'h0);
        check("reset dat_o",    rdat,                32'h0);
        check("reset cnt_en",   {31'h0, cnt_en},     32'h0);
        check("reset cnt_load", {31'h0, cnt_load},   32'h0);
        check("reset load_val", 32'(cnt_load_val),   32'h0);
        check("reset irq",      {31'h0, irq},        32'h0);
        rst = 1'b0;
        tick();

        // Register access table
        for (int i = 0; i < 25; i++) begin
            cnt_val = vecs[i].cnt;
            wb_xfer(vecs[i].we, BASE + {27'h0, vecs[i].off}, vecs[i].sel, vecs[i].wdat, s);
            check($sformatf("vec%0d ack", i), {31'h0, s.acked}, 32'h1);
            check($sformatf("vec%0d latency", i), 32'(s.lat), 32'h1);
            if (!vecs[i].we)
                check($sformatf("vec%0d rdata", i), s.dat, vecs[i].exp_rd);
            check($sformatf("vec%0d load pulse", i), {31'h0, s.ld}, {31'h0, vecs[i].exp_ld});
            if (vecs[i].exp_ld)
                check($sformatf("vec%0d load_val", i), 32'(s.ldv), vecs[i].wdat & 32'h000F_FFFF);
            check($sformatf("vec%0d load after ack", i), {31'h0, cnt_load}, 32'h0);
            check($sformatf("vec%0d irq", i), {31'h0, irq}, 32'h0);
        end

        // Compare match and interrupt rise/fall
        wr(5'h0C, 4'hF, 32'h0000_0010, s);
        wr(5'h00, 4'hF, 32'h0000_0003, s);
        check("ctrl en out", {31'h0, cnt_en}, 32'h1);
        for (int i = 0; i < 5; i++) begin
            cnt_val = seq_cnt[i];
            tick();
            check($sformatf("match seq irq %0d", i), {31'h0, irq}, {31'h0, seq_irq[i]});
        end
        rd(5'h10, s);
        check("status after match", s.dat, 32'h1);
        wr(5'h10, 4'h1, 32'h0000_0001, s);
        check("irq on clear ack", {31'h0, s.irq}, 32'h1);
        check("irq after clear", {31'h0, irq}, 32'h0);
        rd(5'h10, s);
        check("status after clear", s.dat, 32'h0);

        // Wrap to zero with CMP=0
        wr(5'h0C, 4'hF, 32'h0, s);
        cnt_val = 20'hFFFFF;
        tick(); tick();
        check("irq at max count", {31'h0, irq}, 32'h0);
        cnt_val = 20'h00000;
        tick(); tick();
        check("irq after wrap", {31'h0, irq}, 32'h1);
        cnt_val = 20'h00005;
        wr(5'h10, 4'h1, 32'h1, s);
        check("irq after wrap clear", {31'h0, irq}, 32'h0);

        // W1C in the same cycle as a new match: the match survives
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE + 32'h10; sel = 4'h1; wdat = 32'h1;
        cnt_val = 20'h00000;
        tick();
        check("w1c race ack", {31'h0, ack}, 32'h1);
        cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; wdat = 32'h0;
        cnt_val = 20'h00005;
        tick();
        check("w1c race irq", {31'h0, irq}, 32'h1);
        rd(5'h10, s);
        check("w1c race status", s.dat, 32'h1);

        // EN=0 holds MATCH and blocks new matches
        wr(5'h00, 4'hF, 32'h0000_0002, s);
        check("en off irq held", {31'h0, irq}, 32'h1);
        wr(5'h10, 4'h1, 32'h1, s);
        cnt_val = 20'h00000;
        tick(); tick(); tick();
        rd(5'h10, s);
        check("en off no match", s.dat, 32'h0);
        check("en off irq", {31'h0, irq}, 32'h0);

        // Out-of-window access and byte-lane gating
        wb_xfer(1'b1, 32'h3000_0020, 4'hF, 32'hFFFF_FFFF, s);
        check("out of window no ack", {31'h0, s.acked}, 32'h0);
        wr(5'h0C, 4'h1, 32'hFFFF_FFFF, s);
        rd(5'h0C, s);
        check("cmp byte lane 0", s.dat, 32'h0000_00FF);

        // Reset during a pending write
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE; sel = 4'hF; wdat = 32'h3;
        rst = 1'b1;
        tick();
        check("reset mid-write ack", {31'h0, ack}, 32'h0);
        cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; wdat = 32'h0;
        rst = 1'b0;
        tick();
        check("reset mid-write ack later", {31'h0, ack}, 32'h0);
        rd(5'h00, s);
        check("ctrl after reset", s.dat, 32'h0);
        check("en after reset", {31'h0, cnt_en}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
